// File: rtl/msg_poly_encoder.sv
// Captures {msg, coin, pre_k}; streams Decompress_1(msg) as LANES coefficients per beat, idx 0 first.
// Latency: first beat the cycle after accept. Backpressure: beat stalls (stable) while out_ready is low.
module msg_poly_encoder #(
  parameter int KYBER_N = 256,
  parameter int KYBER_Q = 3329,
  parameter int COEFF_W = 12,
  parameter int LANES   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [KYBER_N-1:0]       msg,
  input  logic [KYBER_N-1:0]       coin,
  input  logic [KYBER_N-1:0]       pre_k,
  output logic [KYBER_N-1:0]       coin_out,
  output logic [KYBER_N-1:0]       pre_k_out,
  output logic                     seed_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*COEFF_W-1:0] out_data,
  output logic [7:0]               out_idx,
  output logic                     out_last,
  output logic                     done
);

  localparam logic [COEFF_W-1:0] COEFF_ONE = COEFF_W'((KYBER_Q + 1) / 2);
  localparam logic [7:0]         LAST_IDX  = 8'(KYBER_N - LANES);
  localparam logic [7:0]         STEP      = 8'(LANES);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state, state_nxt;
  logic [KYBER_N-1:0] msg_sr;
  logic [7:0]         idx;
  logic               accept, beat;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = in_valid & in_ready;
  assign beat     = out_valid & out_ready;
  assign out_last = out_valid && (idx == LAST_IDX);
  assign out_idx  = idx;

  // The message is shifted down each beat, so lane j always reads bit j.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < LANES; j++) begin
      if (out_valid && msg_sr[j]) out_data[j*COEFF_W +: COEFF_W] = COEFF_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      msg_sr     <= '0;
      idx        <= '0;
      coin_out   <= '0;
      pre_k_out  <= '0;
      seed_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= beat & out_last;
      if (accept) begin
        msg_sr     <= msg;
        coin_out   <= coin;
        pre_k_out  <= pre_k;
        seed_valid <= 1'b1;
        idx        <= '0;
      end else if (beat) begin
        msg_sr <= msg_sr >> LANES;
        idx    <= out_last ? 8'd0 : idx + STEP;
      end
    end
  end

endmodule
